// File: rtl/mppt_po_controller.sv
// Perturb-and-observe MPPT controller: samples V then I over a req/valid handshake,
// forms P = V*I and steps the PWM duty toward maximum power. Define MPPT_OVP_EN for over-voltage backoff.
module mppt_po_controller #(
  parameter int SETTLE_CYCLES = 64,
  parameter int STEP          = 4,
  parameter int DUTY_MIN      = 16,
  parameter int DUTY_MAX      = 240,
  parameter int DUTY_INIT     = 128,
  parameter int TIMEOUT       = 255,
  parameter int OV_LIMIT      = 230
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [7:0]  sample_data,
  input  logic        sample_valid,
  output logic        sample_req,
  output logic        sample_sel,
  output logic [7:0]  duty,
  output logic        duty_upd,
  output logic        dir,
  output logic [15:0] power,
  output logic        fault,
  output logic        ovp
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    REQ_V  = 3'd2,
    REQ_I  = 3'd3,
    CALC   = 3'd4,
    DECIDE = 3'd5
  } state_t;

  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] TO_LAST     = 16'(TIMEOUT - 1);
  localparam logic [9:0]  STEP_1X     = 10'(STEP);
  localparam logic [9:0]  STEP_2X     = 10'(2 * STEP);
  localparam logic [9:0]  DMIN_10     = 10'(DUTY_MIN);
  localparam logic [9:0]  DMAX_10     = 10'(DUTY_MAX);
  localparam logic [7:0]  DMIN_8      = 8'(DUTY_MIN);
  localparam logic [7:0]  DMAX_8      = 8'(DUTY_MAX);
  localparam logic [7:0]  DUTY_RST    = 8'(DUTY_INIT);
`ifdef MPPT_OVP_EN
  localparam logic [7:0]  OV_LIM_8    = 8'(OV_LIMIT);
`endif

  state_t      state_r, state_nxt;
  logic [15:0] cnt_r, cnt_nxt;
  logic [7:0]  v_r, v_nxt, i_r, i_nxt, duty_r, duty_nxt;
  logic [15:0] power_r, power_nxt, prev_r, prev_nxt;
  logic        v_got_r, v_got_nxt, dir_r, dir_nxt, req_r, req_nxt, sel_r, sel_nxt;
  logic        upd_r, upd_nxt, fault_r, fault_nxt, ovp_r, ovp_nxt;

  logic        accept_s, waiting_s, timeout_s;
  logic        move_up_s, at_max_s, at_min_s;
  logic [9:0]  amt_s, up_sum_s;
  logic [7:0]  step_duty_s;

  assign sample_req = req_r;
  assign sample_sel = sel_r;
  assign duty       = duty_r;
  assign duty_upd   = upd_r;
  assign dir        = dir_r;
  assign power      = power_r;
  assign fault      = fault_r;
  assign ovp        = ovp_r;

  // Handshake qualification: a valid only counts while a request is outstanding
  always_comb begin
    accept_s  = sample_valid & req_r;
    waiting_s = ((state_r == REQ_V) & ~v_got_r) | (state_r == REQ_I);
    timeout_s = waiting_s & ~accept_s & (cnt_r == TO_LAST);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state logic; dropping en aborts from any active state
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE: begin
        if (en && !fault_r) state_nxt = SETTLE;
        else                state_nxt = IDLE;
      end
      SETTLE: begin
        if (!en)                   state_nxt = IDLE;
        else if (cnt_r == 16'd0)   state_nxt = REQ_V;
        else                       state_nxt = SETTLE;
      end
      REQ_V: begin
        if (!en)            state_nxt = IDLE;
        else if (v_got_r)   state_nxt = ovp_r ? DECIDE : REQ_I;
        else if (timeout_s) state_nxt = IDLE;
        else                state_nxt = REQ_V;
      end
      REQ_I: begin
        if (!en)            state_nxt = IDLE;
        else if (accept_s)  state_nxt = CALC;
        else if (timeout_s) state_nxt = IDLE;
        else                state_nxt = REQ_I;
      end
      CALC: begin
        if (!en) state_nxt = IDLE;
        else     state_nxt = DECIDE;
      end
      DECIDE: begin
        if (en) state_nxt = SETTLE;
        else    state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Perturbation step: pick direction from the power trend, then saturate into the duty window
  always_comb begin
    amt_s       = ovp_r ? STEP_2X : STEP_1X;
    move_up_s   = ovp_r ? 1'b0 : ((power_r < prev_r) ? ~dir_r : dir_r);
    up_sum_s    = {2'b00, duty_r} + amt_s;
    at_max_s    = 1'b0;
    at_min_s    = 1'b0;
    step_duty_s = duty_r;
    if (move_up_s) begin
      if (up_sum_s >= DMAX_10) begin
        step_duty_s = DMAX_8;
        at_max_s    = 1'b1;
      end else begin
        step_duty_s = up_sum_s[7:0];
      end
    end else begin
      if ({2'b00, duty_r} <= (DMIN_10 + amt_s)) begin
        step_duty_s = DMIN_8;
        at_min_s    = 1'b1;
      end else begin
        step_duty_s = duty_r - amt_s[7:0];
      end
    end
  end

  // Output and datapath next values; outputs are registered from these
  always_comb begin
    cnt_nxt   = cnt_r;
    v_nxt     = v_r;
    i_nxt     = i_r;
    duty_nxt  = duty_r;
    power_nxt = power_r;
    prev_nxt  = prev_r;
    dir_nxt   = dir_r;
    fault_nxt = fault_r;
    ovp_nxt   = ovp_r;
    upd_nxt   = 1'b0;
    v_got_nxt = (state_r == REQ_V) & (state_nxt == REQ_V) & accept_s;

    // Counter doubles as settle down-counter and per-request wait counter
    if (state_nxt != state_r) begin
      cnt_nxt = (state_nxt == SETTLE) ? SETTLE_LOAD : 16'd0;
    end else if (state_r == SETTLE) begin
      cnt_nxt = cnt_r - 16'd1;
    end else if (waiting_s) begin
      cnt_nxt = cnt_r + 16'd1;
    end else begin
      cnt_nxt = cnt_r;
    end

    if ((state_r == REQ_V) && accept_s && en) begin
      v_nxt = sample_data;
`ifdef MPPT_OVP_EN
      ovp_nxt = (sample_data > OV_LIM_8);
`else
      ovp_nxt = 1'b0;
`endif
    end else begin
      v_nxt = v_r;
    end

    if ((state_r == REQ_I) && accept_s && en) begin
      i_nxt = sample_data;
    end else begin
      i_nxt = i_r;
    end

    if ((state_r == CALC) && en) begin
      power_nxt = 16'(v_r) * 16'(i_r);
    end else begin
      power_nxt = power_r;
    end

    if (state_r == DECIDE) begin
      duty_nxt = step_duty_s;
      upd_nxt  = 1'b1;
      if (ovp_r) begin
        dir_nxt = 1'b0;
      end else begin
        prev_nxt = power_r;
        if (at_max_s)      dir_nxt = 1'b0;
        else if (at_min_s) dir_nxt = 1'b1;
        else               dir_nxt = move_up_s;
      end
    end else begin
      upd_nxt = 1'b0;
    end

    if (timeout_s && en) begin
      fault_nxt = 1'b1;
    end else if ((state_r == IDLE) && !en) begin
      fault_nxt = 1'b0;
    end else begin
      fault_nxt = fault_r;
    end

    req_nxt = ((state_nxt == REQ_V) & ~v_got_nxt) | (state_nxt == REQ_I);
    sel_nxt = (state_nxt == REQ_I);
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= 16'd0;
      v_r     <= 8'd0;
      i_r     <= 8'd0;
      duty_r  <= DUTY_RST;
      power_r <= 16'd0;
      prev_r  <= 16'd0;
      v_got_r <= 1'b0;
      dir_r   <= 1'b1;
      req_r   <= 1'b0;
      sel_r   <= 1'b0;
      upd_r   <= 1'b0;
      fault_r <= 1'b0;
      ovp_r   <= 1'b0;
    end else begin
      cnt_r   <= cnt_nxt;
      v_r     <= v_nxt;
      i_r     <= i_nxt;
      duty_r  <= duty_nxt;
      power_r <= power_nxt;
      prev_r  <= prev_nxt;
      v_got_r <= v_got_nxt;
      dir_r   <= dir_nxt;
      req_r   <= req_nxt;
      sel_r   <= sel_nxt;
      upd_r   <= upd_nxt;
      fault_r <= fault_nxt;
      ovp_r   <= ovp_nxt;
    end
  end

endmodule

// File: tb/tb_mppt_po_controller.sv
// Randomized bench for mppt_po_controller: a sample responder drives the handshake and a
// transaction-level P&O model predicts duty, direction and power after every update.
module tb_mppt_po_controller;

  localparam int SETTLE = 64;
  localparam int STEP   = 4;
  localparam int DMIN   = 16;
  localparam int DMAX   = 240;
  localparam int TMO    = 255;

  logic        clk = 1'b0;
  logic        rst_n, en, sample_valid;
  logic [7:0]  sample_data;
  logic        sample_req, sample_sel, duty_upd, dir, fault, ovp;
  logic [7:0]  duty;
  logic [15:0] power;

  mppt_po_controller dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sample_data(sample_data),
    .sample_valid(sample_valid), .sample_req(sample_req), .sample_sel(sample_sel),
    .duty(duty), .duty_upd(duty_upd), .dir(dir), .power(power),
    .fault(fault), .ovp(ovp)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: one P&O iteration per accepted (v, i) pair
  int m_duty = 128, m_dir = 1, m_prev = 0, m_power = 0, m_upds = 0;

  task automatic model_step(input int v, input int i);
    int p, nd;
    p = v * i;
    if (p < m_prev) m_dir = 1 - m_dir;
    nd = (m_dir == 1) ? m_duty + STEP : m_duty - STEP;
    if (nd >= DMAX) begin
      nd = DMAX; m_dir = 0;
    end else if (nd <= DMIN) begin
      nd = DMIN; m_dir = 1;
    end
    m_duty = nd; m_prev = p; m_power = p; m_upds++;
  endtask

  // Sample source behind the ui_in path
  logic       resp_on = 1'b0, skip_i = 1'b0, spur = 1'b0;
  int         resp_dly = 0;
  logic [7:0] cur_v = 8'd0, cur_i = 8'd0;
  int         upd_seen = 0;

  initial begin : responder
    int wcnt;
    wcnt = 0;
    sample_valid = 1'b0;
    sample_data  = 8'd0;
    forever begin
      @(negedge clk);
      if (sample_valid) begin
        sample_valid = 1'b0;
        sample_data  = 8'($urandom);
        wcnt = 0;
      end else if (spur) begin
        sample_valid = 1'b1;
        sample_data  = 8'($urandom);
      end else if (resp_on && sample_req && !(skip_i && sample_sel)) begin
        if (wcnt >= resp_dly) begin
          sample_valid = 1'b1;
          sample_data  = sample_sel ? cur_i : cur_v;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  initial begin : upd_monitor
    forever begin
      @(negedge clk);
      if (duty_upd === 1'b1) upd_seen++;
    end
  end

  task automatic wait_upd(output int cyc);
    cyc = 0;
    while (duty_upd !== 1'b1 && cyc < 1200) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("upd_arrived", int'(duty_upd), 1);
  endtask

  task automatic do_iter(input int v, input int i, input int dly, output int cyc);
    cur_v = 8'(v); cur_i = 8'(i); resp_dly = dly; resp_on = 1'b1;
    wait_upd(cyc);
    model_step(v, i);
    check_eq("duty", int'(duty), m_duty);
    check_eq("dir", int'(dir), m_dir);
    check_eq("power", int'(power), m_power);
    check_eq("fault_clear", int'(fault), 0);
    @(negedge clk);
    check_eq("upd_one_cycle", int'(duty_upd), 0);
  endtask

  initial begin : main
    int cyc, n, icyc, reqc, updc, v, i;
    rst_n = 1'b0; en = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_duty", int'(duty), 128);
    check_eq("rst_dir", int'(dir), 1);
    check_eq("rst_req", int'(sample_req), 0);
    check_eq("rst_sel", int'(sample_sel), 0);
    check_eq("rst_upd", int'(duty_upd), 0);
    check_eq("rst_power", int'(power), 0);
    check_eq("rst_fault", int'(fault), 0);
    check_eq("rst_ovp", int'(ovp), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // First step with zero-wait responses: latency from the enabling edge
    en = 1'b1;
    do_iter(150, 45, 0, cyc);
    check_eq("latency", cyc - 1, SETTLE + 5);
    check_eq("first_duty", int'(duty), 132);
    do_iter(100, 45, 0, cyc);
    do_iter(50, 45, 1, cyc);

    // Rising power walks duty up into the upper clamp
    for (int k = 1; k <= 30; k++) begin
      do_iter(60 + k, 60 + k, $urandom_range(0, 3), cyc);
      if (m_duty == DMAX) check_eq("clamp_dir_max", int'(dir), 0);
    end

    // Equal power keeps direction, walking duty down into the lower clamp
    for (int k = 0; k < 60; k++) begin
      do_iter(91, 91, $urandom_range(0, 2), cyc);
      if (m_duty == DMIN) check_eq("clamp_dir_min", int'(dir), 1);
    end

    for (int k = 0; k < 15; k++) begin
      do_iter($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 8), cyc);
    end

    // Valid arriving in the last allowed cycle beats the timeout
    do_iter($urandom_range(1, 255), $urandom_range(1, 255), TMO - 1, cyc);

    // Withhold the current sample until timeout
    resp_dly = 0; skip_i = 1'b1; cur_v = 8'd77;
    icyc = 0; n = 0;
    while (fault !== 1'b1 && n < 1500) begin
      @(negedge clk);
      n++;
      if (sample_req && sample_sel) icyc++;
    end
    check_eq("tmo_fault", int'(fault), 1);
    check_eq("tmo_wait_cycles", icyc, TMO);
    check_eq("tmo_req_drop", int'(sample_req), 0);
    check_eq("tmo_duty_hold", int'(duty), m_duty);
    reqc = 0;
    repeat (40) begin
      @(negedge clk);
      if (sample_req) reqc++;
    end
    check_eq("tmo_stays_idle", reqc, 0);
    check_eq("tmo_sticky", int'(fault), 1);
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("fault_cleared", int'(fault), 0);
    skip_i = 1'b0;
    en = 1'b1;
    do_iter(120, 60, 0, cyc);

    // Abort during SETTLE, with spurious valids while idle
    repeat (10) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check_eq("abort_settle_req", int'(sample_req), 0);
    spur = 1'b1;
    reqc = 0; updc = upd_seen;
    repeat (100) begin
      @(negedge clk);
      if (sample_req) reqc++;
      if (n == 10) spur = 1'b0;
    end
    spur = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("abort_settle_noreq", reqc, 0);
    check_eq("abort_settle_noupd", upd_seen - updc, 0);
    check_eq("abort_settle_duty", int'(duty), m_duty);
    check_eq("abort_settle_dir", int'(dir), m_dir);
    en = 1'b1;
    do_iter(30, 30, 2, cyc);

    // Abort during REQ_V
    resp_on = 1'b0;
    n = 0;
    while (sample_req !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq("reqv_seen", int'(sample_req), 1);
    check_eq("reqv_sel", int'(sample_sel), 0);
    en = 1'b0;
    @(negedge clk);
    check_eq("abort_reqv_req", int'(sample_req), 0);
    updc = upd_seen;
    repeat (20) @(negedge clk);
    check_eq("abort_reqv_noupd", upd_seen - updc, 0);
    check_eq("abort_reqv_duty", int'(duty), m_duty);
    en = 1'b1;
    v = $urandom_range(0, 255); i = $urandom_range(0, 255);
    do_iter(v, i, 1, cyc);
    do_iter(200, 200, 0, cyc);

    repeat (3) @(negedge clk);
    check_eq("upd_count", upd_seen, m_upds);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
